// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: state encoding, register
// offsets and STATUS field positions.
package timer_pkg;

  localparam int STATE_W      = 2;

  localparam int OFF_STATUS   = 0;
  localparam int OFF_GOAL     = 1;
  localparam int OFF_CURR     = 2;

  localparam int BIT_START    = 0;
  localparam int BIT_STOP     = 1;
  localparam int BIT_STATE_LO = 2;
  localparam int STATUS_W     = BIT_STATE_LO + STATE_W;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_COMPLETE = 2'd2
  } timer_state_e;

  function automatic logic [STATUS_W-1:0] pack_status(timer_state_e st, logic stop, logic start);
    return {st, stop, start};
  endfunction

endpackage

// File: rtl/timer_if.sv
// APB-style register bus between a requester and the timer.
interface timer_if #(
  parameter int timerbits = 8,
  parameter int addrWidth = 32
);
  logic                 sel;
  logic                 enable;
  logic                 write;
  logic [addrWidth-1:0] addr;
  logic [timerbits-1:0] wdata;
  logic [timerbits-1:0] rdata;
  logic                 ready;
  logic                 slverr;

  modport master (output sel, enable, write, addr, wdata, input rdata, ready, slverr);
  modport slave  (input sel, enable, write, addr, wdata, output rdata, ready, slverr);
endinterface

// File: rtl/timer_core.sv
// Counter and run-state machine; a STATUS write (start/clear) always
// overrides the count step in the same cycle.
module timer_core
  import timer_pkg::*;
#(
  parameter int timerbits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic [timerbits-1:0] goal,
  output logic [timerbits-1:0] curr,
  output timer_state_e         state,
  output logic                 start_bit,
  output logic                 stop_bit
);

  timer_state_e         state_d, state_q;
  logic [timerbits-1:0] curr_d, curr_q;
  logic                 start_d, start_q;
  logic                 stop_d, stop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      curr_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      curr_q  <= curr_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    curr_d  = curr_q;
    start_d = start_q;
    stop_d  = stop_q;
    if (clear) begin
      state_d = ST_IDLE;
      curr_d  = '0;
      start_d = 1'b0;
      stop_d  = 1'b0;
    end else if (start) begin
      stop_d = stop;
      if (state_q == ST_IDLE) begin
        state_d = ST_RUNNING;
        curr_d  = '0;
        start_d = 1'b1;
      end
    end else if (state_q == ST_RUNNING && !stop_q) begin
      // >= rather than == so a goal lowered below curr still terminates
      if (curr_q >= goal) state_d = ST_COMPLETE;
      else                curr_d  = curr_q + timerbits'(1);
    end
  end

  assign curr      = curr_q;
  assign state     = state_q;
  assign start_bit = start_q;
  assign stop_bit  = stop_q;

endmodule

// File: rtl/timer.sv
// Timer register block: bus decode, GOAL register and read mux around
// timer_core. Zero-wait-state access; bad accesses flag slverr.
module timer
  import timer_pkg::*;
#(
  parameter int timerbits     = 8,
  parameter int addrWidth     = 32,
  parameter int timerBaseAddr = 0
) (
  input  logic  clk,
  input  logic  reset,
  timer_if.slave bus
);

  localparam logic [addrWidth-1:0] ADDR_STATUS = addrWidth'(timerBaseAddr + OFF_STATUS);
  localparam logic [addrWidth-1:0] ADDR_GOAL   = addrWidth'(timerBaseAddr + OFF_GOAL);
  localparam logic [addrWidth-1:0] ADDR_CURR   = addrWidth'(timerBaseAddr + OFF_CURR);

  logic                 access, hit_status, hit_goal, hit_curr, bad_access;
  logic                 status_we, goal_we, core_start, core_clear;
  logic [timerbits-1:0] goal_d, goal_q, curr, rdata_c;
  timer_state_e         state;
  logic                 start_bit, stop_bit;

  always_comb begin
    access     = bus.sel & bus.enable;
    hit_status = (bus.addr == ADDR_STATUS);
    hit_goal   = (bus.addr == ADDR_GOAL);
    hit_curr   = (bus.addr == ADDR_CURR);
    bad_access = ~(hit_status | hit_goal | hit_curr) | (bus.write & hit_curr);
    status_we  = access & bus.write & hit_status;
    goal_we    = access & bus.write & hit_goal;
    core_start = status_we & bus.wdata[BIT_START];
    core_clear = status_we & ~bus.wdata[BIT_START];
    goal_d     = goal_we ? bus.wdata : goal_q;
    rdata_c    = '0;
    if (access && !bus.write) begin
      if (hit_status)    rdata_c = timerbits'(pack_status(state, stop_bit, start_bit));
      else if (hit_goal) rdata_c = goal_q;
      else if (hit_curr) rdata_c = curr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) goal_q <= '0;
    else        goal_q <= goal_d;
  end

  timer_core #(.timerbits(timerbits)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .stop      (bus.wdata[BIT_STOP]),
    .clear     (core_clear),
    .goal      (goal_q),
    .curr      (curr),
    .state     (state),
    .start_bit (start_bit),
    .stop_bit  (stop_bit)
  );

  // Outputs are held quiet for the whole time reset is asserted
  assign bus.ready  = reset & access;
  assign bus.slverr = reset & access & bad_access;
  assign bus.rdata  = reset ? rdata_c : '0;

endmodule

// File: tb/tb_timer.sv
// Bench for timer: directed scenarios plus randomized bus traffic checked
// against a rule-level reference model of the register block.
module tb_timer;

  localparam int TB_W = 8;
  localparam int AW   = 32;
  localparam int BASE = 0;

  typedef struct packed {
    int state;
    int start;
    int stop;
    int curr;
    int goal;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  mdl_t m;

  always #5 clk = ~clk;

  timer_if #(.timerbits(TB_W), .addrWidth(AW)) bus ();

  timer #(.timerbits(TB_W), .addrWidth(AW), .timerBaseAddr(BASE)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic mdl_t model_next(mdl_t cur, logic s, logic e, logic w,
                                      logic [AW-1:0] a, logic [TB_W-1:0] d);
    mdl_t nx;
    logic wr_acc;
    nx = cur;
    wr_acc = s & e & w;
    if (wr_acc && a == AW'(BASE)) begin
      if (!d[0]) begin
        nx.state = 0; nx.curr = 0; nx.start = 0; nx.stop = 0;
      end else if (cur.state == 0) begin
        nx.state = 1; nx.curr = 0; nx.start = 1; nx.stop = int'(d[1]);
      end else begin
        nx.stop = int'(d[1]);
      end
      return nx;
    end
    if (cur.state == 1 && cur.stop == 0) begin
      if (cur.curr >= cur.goal) nx.state = 2;
      else                      nx.curr  = cur.curr + 1;
    end
    if (wr_acc && a == AW'(BASE + 1)) nx.goal = int'(d);
    return nx;
  endfunction

  function automatic logic [TB_W-1:0] exp_read(mdl_t cur, logic [AW-1:0] a);
    if (a == AW'(BASE))     return TB_W'(cur.state * 4 + cur.stop * 2 + cur.start);
    if (a == AW'(BASE + 1)) return TB_W'(cur.goal);
    if (a == AW'(BASE + 2)) return TB_W'(cur.curr);
    return '0;
  endfunction

  function automatic logic exp_err(logic w, logic [AW-1:0] a);
    return (a > AW'(BASE + 2)) || (w && a == AW'(BASE + 2));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, bus.sel, bus.enable, bus.write, bus.addr, bus.wdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [TB_W-1:0] d,
                      output logic [TB_W-1:0] rd, output logic err, output logic rdy,
                      output logic [TB_W-1:0] mexp);
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = wr; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    @(negedge clk);
    rd = bus.rdata; err = bus.slverr; rdy = bus.ready;
    mexp = wr ? '0 : exp_read(m, a);
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [AW-1:0] a, input logic [TB_W-1:0] d);
    logic [TB_W-1:0] rd, me;
    logic err, rdy;
    xfer(1'b1, a, d, rd, err, rdy, me);
    check({tag, ".ready"},  32'(rdy), 32'(1));
    check({tag, ".slverr"}, 32'(err), 32'(exp_err(1'b1, a)));
  endtask

  task automatic rd_val(input string tag, input logic [AW-1:0] a, output logic [TB_W-1:0] rd);
    logic [TB_W-1:0] me;
    logic err, rdy;
    xfer(1'b0, a, '0, rd, err, rdy, me);
    check({tag, ".ready"},  32'(rdy), 32'(1));
    check({tag, ".slverr"}, 32'(err), 32'(exp_err(1'b0, a)));
    check({tag, ".model"},  32'(rd),  32'(me));
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [TB_W-1:0] exp);
    logic [TB_W-1:0] rd;
    rd_val(tag, a, rd);
    check({tag, ".rdata"}, 32'(rd), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TB_W-1:0] c1, c2, rd, me, d;
    logic [AW-1:0]   a;
    logic            err, rdy, w;
    int              r;

    rst_n = 1'b0;
    bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready",  32'(bus.ready),  32'(0));
    check("rst.rdata",  32'(bus.rdata),  32'(0));
    check("rst.slverr", 32'(bus.slverr), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    rd_chk("status_after_reset", AW'(BASE), 8'h00);

    // unmapped address: error, no state change
    wr_chk("wr_unmapped", AW'(BASE + 3), 8'd25);
    xfer(1'b0, AW'(BASE + 3), '0, rd, err, rdy, me);
    check("rd_unmapped.slverr", 32'(err), 32'(1));
    check("rd_unmapped.rdata",  32'(rd),  32'(0));
    rd_chk("goal_untouched", AW'(BASE + 1), 8'h00);
    wr_chk("wr_curr", AW'(BASE + 2), 8'h11);
    rd_chk("curr_untouched", AW'(BASE + 2), 8'h00);

    // sel low with enable/write high: ignored
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.enable = 1'b1; bus.write = 1'b1; bus.addr = AW'(BASE); bus.wdata = 8'h01;
    @(negedge clk);
    check("nosel.ready",  32'(bus.ready),  32'(0));
    check("nosel.rdata",  32'(bus.rdata),  32'(0));
    check("nosel.slverr", 32'(bus.slverr), 32'(0));
    @(posedge clk); #1;
    bus.enable = 1'b0; bus.write = 1'b0;
    rd_chk("status_nosel", AW'(BASE), 8'h00);

    // start a count to 25
    wr_chk("wr_goal25", AW'(BASE + 1), 8'd25);
    wr_chk("wr_start", AW'(BASE), 8'h01);
    rd_val("curr_running", AW'(BASE + 2), c1);
    check("curr_running.nonzero", 32'(c1 != 0), 32'(1));
    rd_chk("status_running", AW'(BASE), 8'h05);
    repeat (30) @(posedge clk);
    rd_chk("status_complete", AW'(BASE), 8'h09);
    rd_chk("curr_complete", AW'(BASE + 2), 8'd25);

    // clear, restart, then pause
    wr_chk("wr_clear", AW'(BASE), 8'h00);
    rd_chk("status_cleared", AW'(BASE), 8'h00);
    rd_chk("curr_cleared", AW'(BASE + 2), 8'h00);
    wr_chk("wr_goal100", AW'(BASE + 1), 8'd100);
    wr_chk("wr_start2", AW'(BASE), 8'h01);
    wr_chk("wr_stop", AW'(BASE), 8'h03);
    rd_val("curr_hold1", AW'(BASE + 2), c1);
    repeat (4) @(posedge clk);
    rd_val("curr_hold2", AW'(BASE + 2), c2);
    check("curr_hold.equal", 32'(c2), 32'(c1));
    check("curr_hold.nonzero", 32'(c1 != 0), 32'(1));
    rd_chk("status_stopped", AW'(BASE), 8'h07);

    // randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)      a = AW'(BASE);
      else if (r <= 5) a = AW'(BASE + 1);
      else if (r <= 7) a = AW'(BASE + 2);
      else if (r == 8) a = AW'(BASE + 3);
      else             a = AW'(BASE + 'h100);
      w = 1'($urandom_range(0, 1));
      if (a == AW'(BASE + 1)) d = TB_W'($urandom_range(0, 20));
      else begin
        d = TB_W'($urandom);
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      end
      xfer(w, a, d, rd, err, rdy, me);
      check("rand.ready",  32'(rdy), 32'(1));
      check("rand.slverr", 32'(err), 32'(exp_err(w, a)));
      check("rand.rdata",  32'(rd),  32'(me));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // reset in the middle of a count
    wr_chk("wr_clear2", AW'(BASE), 8'h00);
    wr_chk("wr_goal200", AW'(BASE + 1), 8'd200);
    wr_chk("wr_start3", AW'(BASE), 8'h01);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.sel = 1'b1; bus.enable = 1'b1; bus.write = 1'b0; bus.addr = AW'(BASE + 2);
    #1;
    check("midrst.ready", 32'(bus.ready), 32'(0));
    check("midrst.rdata", 32'(bus.rdata), 32'(0));
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.enable = 1'b0;
    rst_n = 1'b1;
    rd_chk("status_after_midrst", AW'(BASE), 8'h00);
    rd_chk("curr_after_midrst", AW'(BASE + 2), 8'h00);
    rd_chk("goal_after_midrst", AW'(BASE + 1), 8'h00);
    repeat (3) @(posedge clk);
    rd_chk("curr_stays_zero", AW'(BASE + 2), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter timerbits, default 8: width of the counter, goal and data bus.
REQ-002 SHALL have parameter addrWidth, default 32: address bus width.
REQ-003 SHALL have parameter timerBaseAddr, default 0: base address of the register block.
REQ-004 Ports, one clock; reset is asynchronous and active-low:
  clk  in  1  clock
  reset  in  1  asynchronous active-low reset
  sel  in  1  APB-style select
  enable  in  1  access phase
  write  in  1  1=write, 0=read
  addr  in  addrWidth  byte address
  wdata  in  timerbits  write data
  rdata  out  timerbits  read data
  ready  out  1  transfer complete
  slverr  out  1  transfer error

Function
REQ-005 Register map: STATUS at timerBaseAddr; GOAL at timerBaseAddr+1 (RW); CURR at timerBaseAddr+2 (RO).
REQ-006 STATUS layout: bit0 START (RW), bit1 STOP (RW), bits3:2 STATE (RO: IDLE=0, RUNNING=1, COMPLETE=2); other bits read 0.
REQ-007 Access phase is sel=1 and enable=1; ready SHALL be 1 combinationally in that phase (zero wait states) and 0 otherwise.
REQ-008 With sel=0, writes SHALL have no effect and rdata/slverr SHALL be 0.
REQ-009 In the access phase, rdata SHALL carry the addressed register for reads; otherwise rdata SHALL be 0.
REQ-010 Unmapped address, or a write to CURR, in the access phase: no register change, rdata=0, slverr=1, ready=1.
REQ-011 Register writes SHALL take effect on the clk edge ending the access phase.
REQ-012 STATUS write with START=1 while IDLE: CURR<=0, STATE<=RUNNING, START/STOP latch the written values.
REQ-013 STATUS write with START=1 while RUNNING or COMPLETE: only STOP updates; CURR and STATE are unchanged.
REQ-014 STATUS write with START=0: STATE<=IDLE, CURR<=0, START<=0, STOP<=0.
REQ-015 While RUNNING and STOP=0, each clk: if CURR>=GOAL then STATE<=COMPLETE (CURR holds), else CURR<=CURR+1.
REQ-016 While RUNNING and STOP=1, CURR SHALL hold and STATE stays RUNNING; clearing STOP resumes counting.
REQ-017 COMPLETE SHALL persist, with CURR held, until a START=0 write.
REQ-018 GOAL writes take effect immediately in any state; GOAL=0 completes on the first running cycle; the >= compare prevents wrap-around.
REQ-019 Count increment and a simultaneous STATUS write in the same cycle: the write wins.

Reset
REQ-020 reset=0 SHALL asynchronously clear CURR, GOAL, START and STOP and set STATE=IDLE; rdata, ready and slverr are then 0.
REQ-021 Reset asserted mid-count SHALL abort the count; no register state survives reset.

Structure
REQ-022 A package timer_pkg SHALL hold the state enum, register offsets (0/1/2), STATUS bit positions and the state-field width (2).
REQ-023 The counter/FSM SHALL be a sub-module timer_core (inputs start/stop/clear/goal, outputs curr/state), with bus decode in timer.

Verification
REQ-024 Write GOAL at address 3 and read address 3 -> slverr=1, rdata=0, no register changes.
REQ-025 Write and read STATUS with sel=0 -> no effect, rdata=0.
REQ-026 After reset, read STATUS -> 0x00; write GOAL=25, write STATUS=0x01, then read CURR -> nonzero; read STATUS -> 0x05.
REQ-027 Wait 20+ cycles after the reads in REQ-026 -> STATUS=0x09 and CURR=25.
REQ-028 Write STATUS=0x00 -> STATUS=0x00 and CURR=0; write GOAL=100, STATUS=0x01, then STATUS=0x03 -> two CURR reads are equal and nonzero, STATUS=0x07.
REQ-029 Assert reset while RUNNING -> STATUS=0x00, CURR=0, GOAL=0 immediately.
